dmem_arbiter: RTL
=================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter DBITS, default 32, data and address width.
REQ-002 Parameter DMEMADDRBITS, default 16, byte-address bits decoded into D-MEM.
REQ-003 Parameter DMEMWORDBITS, default 2, byte-offset bits within a word.
REQ-004 Parameter STARVE_LIMIT, default 4, consecutive denied cycles before the loader port wins priority (range 1..7).
REQ-005 Ports:
  clk  in  1  sole clock, rising edge.
  reset  in  1  asynchronous, active-low reset.
  p_req  in  1  pipeline (MEM stage) access request.
  p_we  in  1  pipeline write (SW_I) when 1, read (LW_I) when 0.
  p_addr  in  DBITS  pipeline byte address.
  p_wdata  in  DBITS  pipeline store data.
  p_gnt  out  1  pipeline access issued this cycle.
  p_rvalid  out  1  pipeline read data valid.
  p_rdata  out  DBITS  pipeline read data.
  d_req, d_we, d_addr, d_wdata  in  1/1/DBITS/DBITS  loader/debug port, same meaning as p_*.
  d_gnt, d_rvalid, d_rdata  out  1/1/DBITS  loader port grant and read return.
  mem_en  out  1  D-MEM access strobe.
  mem_we  out  1  D-MEM write enable.
  mem_addr  out  DMEMADDRBITS-DMEMWORDBITS  D-MEM word index.
  mem_wdata  out  DBITS  D-MEM write data.
  mem_rdata  in  DBITS  D-MEM read data, valid the cycle after a read access.
  stall_pipe  out  1  pipeline must hold its MEM latch.
  err_misaligned  out  1  one-cycle pulse on a misaligned granted access.

Function
REQ-006 At most one of p_gnt and d_gnt SHALL be 1 in any cycle; each grant is combinational from the current req and arbiter state.
REQ-007 A requester SHALL hold req, we, addr and wdata stable until granted; the arbiter SHALL NOT buffer requests.
REQ-008 The arbiter SHALL have two priority states: P_PRIO (default) and D_PRIO.
REQ-009 In P_PRIO, p_req wins; d_req is granted only when p_req=0.
REQ-010 In D_PRIO, d_req wins; p_req is granted only when d_req=0.
REQ-011 A 3-bit starve_cnt SHALL increment each cycle d_req=1 and d_gnt=0, saturating at STARVE_LIMIT, and SHALL clear when d_gnt=1 or d_req=0.
REQ-012 The state SHALL be D_PRIO exactly when starve_cnt==STARVE_LIMIT, and P_PRIO otherwise; after one loader grant it returns to P_PRIO.
REQ-013 stall_pipe SHALL equal p_req AND NOT p_gnt.
REQ-014 On a grant, mem_addr SHALL be addr[DMEMADDRBITS-1:DMEMWORDBITS] of the winner; address bits above DMEMADDRBITS-1 SHALL be ignored.
REQ-015 On a grant, mem_we SHALL equal the winner's we and mem_wdata its wdata; with no grant, mem_en=0 and mem_we=0.
REQ-016 If a granted address has addr[DMEMWORDBITS-1:0]!=0, the grant SHALL still be given, mem_en SHALL be 0, no rvalid SHALL follow, and err_misaligned SHALL pulse 1 on the next cycle.
REQ-017 For a granted aligned read, the matching *_rvalid SHALL be 1 exactly one cycle later, with *_rdata=mem_rdata that cycle.
REQ-018 Writes SHALL produce no rvalid.
REQ-019 p_rdata and d_rdata SHALL hold their last returned value when rvalid=0.
REQ-020 Back-to-back grants SHALL be allowed every cycle, including read after write to the same word; in that case the read returns the newly written data.

Reset
REQ-021 While reset=0, asynchronously: starve_cnt=0, state=P_PRIO, p_rvalid=d_rvalid=0, err_misaligned=0, p_rdata=d_rdata=0.
REQ-022 While reset=0: p_gnt=d_gnt=0, mem_en=mem_we=0, and stall_pipe=p_req.
REQ-023 A read return pending at reset assertion SHALL be discarded; no rvalid SHALL appear after reset deasserts.

Verification
REQ-024 Both ports read continuously (p_addr=0x10, d_addr=0x20) -> p_gnt for 4 cycles, then d_gnt on cycle 5 with mem_addr=0x8; d_rvalid on cycle 6; starve_cnt back to 0.
REQ-025 Pipeline SW to 0x40 with data 0xDEADBEEF, then LW from 0x40 on the next cycle -> mem_we=1 then 0 at mem_addr=0x10; p_rvalid with p_rdata=0xDEADBEEF one cycle after the read grant.
REQ-026 d_req alone with read at 0x3 -> d_gnt=1, mem_en=0, err_misaligned=1 next cycle, no d_rvalid.
REQ-027 p_req held with d_req in D_PRIO -> stall_pipe=1 for exactly that cycle, p_gnt the following cycle.
REQ-028 Reset asserted the cycle after a granted read -> no rvalid ever asserts; all outputs match REQ-021 and REQ-022 until reset deasserts.
REQ-029 p_addr=0x0001_0004 -> mem_addr=0x1 (upper bits ignored), and the read data returns normally.

Source files
------------

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - D-MEM arbiter between the pipeline MEM stage and the loader/debug port
// Pipeline has priority until the loader has been denied STARVE_LIMIT cycles in a row.

module dmem_arbiter #(
    parameter int DBITS        = 32,
    parameter int DMEMADDRBITS = 16,
    parameter int DMEMWORDBITS = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 p_req,
    input  logic                                 p_we,
    input  logic [DBITS-1:0]                     p_addr,
    input  logic [DBITS-1:0]                     p_wdata,
    output logic                                 p_gnt,
    output logic                                 p_rvalid,
    output logic [DBITS-1:0]                     p_rdata,
    input  logic                                 d_req,
    input  logic                                 d_we,
    input  logic [DBITS-1:0]                     d_addr,
    input  logic [DBITS-1:0]                     d_wdata,
    output logic                                 d_gnt,
    output logic                                 d_rvalid,
    output logic [DBITS-1:0]                     d_rdata,
    output logic                                 mem_en,
    output logic                                 mem_we,
    output logic [DMEMADDRBITS-DMEMWORDBITS-1:0] mem_addr,
    output logic [DBITS-1:0]                     mem_wdata,
    input  logic [DBITS-1:0]                     mem_rdata,
    output logic                                 stall_pipe,
    output logic                                 err_misaligned
);

    typedef enum logic {
        P_PRIO = 1'b0,
        D_PRIO = 1'b1
    } prio_e;

    localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

    prio_e                 state_q, state_d;
    logic [2:0]            starve_q, starve_d;
    logic                  p_pend_q, d_pend_q;
    logic                  err_q;
    logic [DBITS-1:0]      p_hold_q, d_hold_q;

    logic                  gnt_any;
    logic                  sel_we;
    logic [DBITS-1:0]      sel_addr;
    logic [DBITS-1:0]      sel_wdata;
    logic                  misaligned;
    logic                  unused_addr_bits;

    // Priority state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= P_PRIO;
            starve_q <= 3'd0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
        end
    end

    // Loader starvation count; D_PRIO is entered exactly when it saturates
    always_comb begin
        starve_d = 3'd0;
        if (d_req && !d_gnt) begin
            starve_d = (starve_q == LIMIT) ? LIMIT : starve_q + 3'd1;
        end
        state_d = (starve_d == LIMIT) ? D_PRIO : P_PRIO;
    end

    always_comb begin
        p_gnt = 1'b0;
        d_gnt = 1'b0;
        if (reset) begin
            if (state_q == D_PRIO) begin
                d_gnt = d_req;
                p_gnt = p_req && !d_req;
            end else begin
                p_gnt = p_req;
                d_gnt = d_req && !p_req;
            end
        end
    end

    // Winner mux; a misaligned winner still consumes its grant but never touches memory
    always_comb begin
        gnt_any    = p_gnt || d_gnt;
        sel_we     = d_gnt ? d_we    : p_we;
        sel_addr   = d_gnt ? d_addr  : p_addr;
        sel_wdata  = d_gnt ? d_wdata : p_wdata;
        misaligned = |sel_addr[DMEMWORDBITS-1:0];
        mem_en     = gnt_any && !misaligned;
        mem_we     = gnt_any && sel_we;
        mem_addr   = sel_addr[DMEMADDRBITS-1:DMEMWORDBITS];
        mem_wdata  = sel_wdata;
    end

    assign unused_addr_bits = ^{p_addr[DBITS-1:DMEMADDRBITS], d_addr[DBITS-1:DMEMADDRBITS]};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            p_pend_q <= 1'b0;
            d_pend_q <= 1'b0;
            err_q    <= 1'b0;
            p_hold_q <= '0;
            d_hold_q <= '0;
        end else begin
            p_pend_q <= p_gnt && !p_we && !misaligned;
            d_pend_q <= d_gnt && !d_we && !misaligned;
            err_q    <= gnt_any && misaligned;
            if (p_pend_q) begin
                p_hold_q <= mem_rdata;
            end
            if (d_pend_q) begin
                d_hold_q <= mem_rdata;
            end
        end
    end

    // Read data passes straight through on the return cycle and is held afterwards
    assign p_rvalid       = p_pend_q;
    assign d_rvalid       = d_pend_q;
    assign p_rdata        = p_pend_q ? mem_rdata : p_hold_q;
    assign d_rdata        = d_pend_q ? mem_rdata : d_hold_q;
    assign err_misaligned = err_q;
    assign stall_pipe     = p_req && !p_gnt;

endmodule
